// File: rtl/uart_tx_frame.sv
// UART transmitter: frames a byte as start, LSB-first data, optional parity and stop,
// paced by the shared bit_tick strobe, with back-to-back accept at the stop tick.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_tick,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  data_ack,
  output logic                  tx_out,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  state_e                  state_q, state_d;
  logic                    tx_q, tx_d;
  logic                    busy_q, busy_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic                    par_en_q, par_en_d;
  logic                    par_bit_q, par_bit_d;
  logic                    accept_c;
  logic                    last_bit_c;

  assign accept_c   = data_valid & ((state_q == S_IDLE) | ((state_q == S_STOP) & bit_tick));
  assign last_bit_c = (cnt_q == LAST_BIT);

  // ack is a same-cycle pulse; forced low while reset is held
  assign data_ack = accept_c & rst_n;
  assign tx_out   = tx_q;
  assign busy     = busy_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept_c) state_d = S_ARMED;
      S_ARMED:  if (bit_tick) state_d = S_START;
      S_START:  if (bit_tick) state_d = S_DATA;
      S_DATA:   if (bit_tick && last_bit_c) state_d = par_en_q ? S_PARITY : S_STOP;
      S_PARITY: if (bit_tick) state_d = S_STOP;
      S_STOP:   if (bit_tick) state_d = accept_c ? S_START : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values; the line only moves on tick edges
  always_comb begin
    tx_d      = tx_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    busy_d    = (state_d != S_IDLE);

    if (accept_c) begin
      shift_d   = p_data;
      par_en_d  = par_en;
      par_bit_d = (^p_data) ^ par_typ;
    end

    case (state_q)
      S_IDLE: tx_d = 1'b1;
      S_ARMED: if (bit_tick) tx_d = 1'b0;
      S_START: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          if (!last_bit_c) begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            tx_d = par_en_q ? par_bit_q : 1'b1;
          end
        end
      end
      S_PARITY: if (bit_tick) tx_d = 1'b1;
      S_STOP:   if (bit_tick) tx_d = accept_c ? 1'b0 : 1'b1;
      default: begin
        tx_d  = 1'b1;
        cnt_d = '0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      shift_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: directed frame table, back-to-back and reset sequences,
// plus randomized traffic checked by a frame-level decoder/scoreboard.
module tb_uart_tx_frame;

  localparam int unsigned DW       = 8;
  localparam int unsigned CW       = 4;
  localparam int unsigned TICK_DIV = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_tick;
  logic          par_en;
  logic          par_typ;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          data_ack;
  logic          tx_out;
  logic          busy;

  uart_tx_frame #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .bit_tick(bit_tick), .par_en(par_en), .par_typ(par_typ),
    .p_data(p_data), .data_valid(data_valid), .data_ack(data_ack), .tx_out(tx_out), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct { logic [DW-1:0] d; logic pe; logic pt; } frame_t;

  // Expected line sequence of a frame, bit i = i-th bit on the wire
  function automatic logic [15:0] frame_bits(input frame_t f);
    logic [15:0] b;
    b = '1;
    b[0] = 1'b0;
    for (int i = 0; i < DW; i++) b[1+i] = f.d[i];
    if (f.pe) b[DW+1] = 1'(($countones(f.d) % 2) == 1) ^ f.pt;
    return b;
  endfunction

  function automatic int frame_len(input frame_t f);
    return DW + 2 + (f.pe ? 1 : 0);
  endfunction

  // Scoreboard / line decoder
  bit            mon_en = 1'b0;
  int            pending = 0;
  bit            in_frame = 1'b0;
  int            pos = 0;
  int            flen = 0;
  logic [15:0]   fbits = '0;
  frame_t        exp_q[$];
  logic          ack_s, tick_s, valid_s, pe_s, pt_s, tx_pre, exp_ack;
  logic [DW-1:0] d_s;

  initial forever begin
    @(negedge clk);
    ack_s = data_ack; tick_s = bit_tick; valid_s = data_valid;
    d_s = p_data; pe_s = par_en; pt_s = par_typ; tx_pre = tx_out;
    exp_ack = valid_s && (pending == 0 || (in_frame && pos == flen && tick_s));
    if (mon_en) check("mon_ack", ack_s, exp_ack);
    @(posedge clk);
    #2;
    if (mon_en && rst_n) begin
      if (ack_s) begin
        exp_q.push_back('{d_s, pe_s, pt_s});
        pending++;
      end
      if (!tick_s) begin
        check("mon_tx_hold", tx_out, tx_pre);
      end else begin
        if (in_frame && pos == flen) begin
          void'(exp_q.pop_front());
          pending--;
          in_frame = 1'b0;
        end
        if (in_frame) begin
          check("mon_tx_bit", tx_out, fbits[pos]);
          pos++;
        end else if (tx_out == 1'b0) begin
          check("mon_start_has_frame", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            fbits = frame_bits(exp_q[0]);
            flen = frame_len(exp_q[0]);
            pos = 1;
            in_frame = 1'b1;
          end
        end
      end
      check("mon_busy", busy, pending > 0);
    end
  end

  // One clock; inputs change 1 time unit after the edge
  task automatic cyc(input logic tk);
    bit_tick = tk;
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
  endtask

  task automatic cyc_ack(input logic tk, output logic ack);
    bit_tick = tk;
    #1;
    ack = data_ack;
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
  endtask

  task automatic tick_period();
    cyc(1'b1);
    repeat (TICK_DIV - 1) cyc(1'b0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 40) begin
      tick_period();
      n++;
    end
    check("drain_idle", busy, 0);
  endtask

  typedef struct { logic [DW-1:0] d; logic pe; logic pt; logic coinc; int len; string seq; } vec_t;
  vec_t vecs[7];

  task automatic run_vec(input vec_t v, input string name);
    logic got[24];
    int   n;
    p_data = v.d; par_en = v.pe; par_typ = v.pt; data_valid = 1'b1;
    bit_tick = v.coinc;
    #1;
    check({name, "_ack"}, data_ack, 1);
    @(posedge clk);
    #1;
    bit_tick = 1'b0;
    data_valid = 1'b0;
    check({name, "_busy_after_accept"}, busy, 1);
    check({name, "_ack_single"}, data_ack, 0);
    p_data = DW'($urandom); par_en = ~v.pe; par_typ = ~v.pt;
    n = 0;
    for (int t = 0; t < 20; t++) begin
      cyc(1'b1);
      if (!busy) break;
      got[n] = tx_out;
      n++;
      repeat (TICK_DIV - 1) cyc(1'b0);
    end
    check({name, "_len"}, n, v.len);
    for (int i = 0; i < v.len && i < n; i++)
      check({name, "_bit"}, got[i], (v.seq[i] == "1") ? 1 : 0);
    check({name, "_idle_line"}, tx_out, 1);
  endtask

  initial begin : global_timeout
    #500000;
    failures++;
    $display("FAIL timeout: simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int   n;
    int   ack_idx;
    logic ack_tk, a, got, busy_drop;
    int   acks, reqs;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, "0101001011"};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, "01010010101"};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b0, 11, "01010010111"};
    vecs[3] = '{8'h07, 1'b1, 1'b0, 1'b0, 11, "01110000011"};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1'b1, 11, "01111111111"};
    vecs[5] = '{8'h00, 1'b1, 1'b0, 1'b0, 11, "00000000001"};
    vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b0, 10, "0001111001"};

    rst_n = 1'b0; bit_tick = 1'b0; par_en = 1'b0; par_typ = 1'b0; p_data = '0;
    data_valid = 1'b1;
    #12;
    check("reset_tx", tx_out, 1);
    check("reset_busy", busy, 0);
    check("reset_ack_gated", data_ack, 0);
    data_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    repeat (20) tick_period();
    check("quiet_tx", tx_out, 1);
    check("quiet_busy", busy, 0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: second request held from the first accept onward
    p_data = 8'h55; par_en = 1'b0; par_typ = 1'b0; data_valid = 1'b1;
    #1;
    check("b2b_first_ack", data_ack, 1);
    @(posedge clk);
    #1;
    p_data = 8'h0F;
    got = 1'b0; ack_idx = 0; ack_tk = 1'b0; busy_drop = 1'b0;
    for (int c = 0; c < 80 && !got; c++) begin
      cyc_ack((c % TICK_DIV) == 0, a);
      if (!busy) busy_drop = 1'b1;
      if (a) begin
        got = 1'b1;
        ack_tk = ((c % TICK_DIV) == 0);
        ack_idx = c / TICK_DIV + 1;
      end
    end
    data_valid = 1'b0;
    check("b2b_ack_seen", got, 1);
    check("b2b_ack_tick_index", ack_idx, DW + 3);
    check("b2b_ack_on_tick", ack_tk, 1);
    check("b2b_start_no_gap", tx_out, 0);
    check("b2b_busy_kept", busy_drop, 0);
    check("b2b_busy_now", busy, 1);
    wait_idle(n);
    check("b2b_second_len", n, DW + 2);

    // Asynchronous reset during data bit 3
    p_data = 8'hF0; par_en = 1'b0; data_valid = 1'b1;
    cyc(1'b0);
    data_valid = 1'b0;
    repeat (5) tick_period();
    check("pre_reset_line_bit3", tx_out, 0);
    check("pre_reset_busy", busy, 1);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_tx", tx_out, 1);
    check("async_reset_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_tx", tx_out, 1);
    exp_q.delete();
    pending = 0;
    in_frame = 1'b0;
    mon_en = 1'b1;
    run_vec(vecs[6], "post_reset");

    // Randomized traffic against the scoreboard
    acks = 0; reqs = 0;
    for (int c = 0; c < 20000 && acks < 40; c++) begin
      if (!data_valid && reqs < 40 && $urandom_range(0, 1) == 0) begin
        p_data = DW'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
        data_valid = 1'b1;
        reqs++;
      end else if (!data_valid) begin
        p_data = DW'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      end
      cyc_ack($urandom_range(0, 2) == 0, a);
      if (a) begin
        data_valid = 1'b0;
        acks++;
        p_data = DW'($urandom); par_en = 1'($urandom); par_typ = 1'($urandom);
      end
    end
    check("rand_acks", acks, 40);
    wait_idle(n);
    repeat (3) cyc(1'b0);
    check("rand_pending", pending, 0);
    check("rand_queue_empty", exp_q.size(), 0);
    check("final_tx", tx_out, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
